// File: rtl/sram_port_arbiter_if.sv
// SRAM-like bus port shared by fetch and data: request/payload out, addr_ok/data_ok/rdata back.
interface sram_port_arbiter_if;
   logic        req;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wen, addr, wdata,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wen, addr, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single SRAM bus port between instruction fetch and MEM-stage data accesses,
// one transaction at a time, data first, with a stall request while an access is outstanding.
module sram_port_arbiter (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       inst_req,
   input  logic [31:0]                inst_addr,
   output logic [31:0]                inst_rdata,
   output logic                       inst_done,
   input  logic                       data_req,
   input  logic [3:0]                 data_wen,
   input  logic [31:0]                data_addr,
   input  logic [31:0]                data_wdata,
   output logic [31:0]                data_rdata,
   output logic                       data_done,
   output logic                       stallreq,
   sram_port_arbiter_if.master        mem
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
   typedef enum logic {OWN_INST, OWN_DATA} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q;
   logic        grant, capture;
   logic [3:0]  wen_q;
   logic [31:0] addr_q, wdata_q;

   assign mem.wen   = wen_q;
   assign mem.addr  = addr_q;
   assign mem.wdata = wdata_q;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      grant     = 1'b0;
      capture   = 1'b0;
      mem.req   = 1'b0;
      stallreq  = 1'b0;
      inst_done = 1'b0;
      data_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (inst_req || data_req) begin
               grant    = 1'b1;
               stallreq = 1'b1;
               state_d  = ADDR;
            end
         end
         ADDR: begin
            mem.req  = 1'b1;
            stallreq = 1'b1;
            if (mem.addr_ok) state_d = DATA;
         end
         DATA: begin
            stallreq = 1'b1;
            if (mem.data_ok) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            // Always back to IDLE: a still-held request is only seen as new there.
            inst_done = (owner_q == OWN_INST);
            data_done = (owner_q == OWN_DATA);
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_INST;
         wen_q      <= 4'b0;
         addr_q     <= 32'b0;
         wdata_q    <= 32'b0;
         inst_rdata <= 32'b0;
         data_rdata <= 32'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            if (data_req) begin
               owner_q <= OWN_DATA;
               wen_q   <= data_wen;
               addr_q  <= data_addr;
               wdata_q <= data_wdata;
            end else begin
               owner_q <= OWN_INST;
               wen_q   <= 4'b0;
               addr_q  <= inst_addr;
               wdata_q <= 32'b0;
            end
         end
         if (capture) begin
            if (owner_q == OWN_INST) inst_rdata <= mem.rdata;
            else if (wen_q == 4'b0)  data_rdata <= mem.rdata;
         end
      end
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; each cycle inputs are driven 1ns after the rising edge
// and outputs are checked 1ns later.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_done;
   logic        data_req;
   logic [3:0]  data_wen;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_done;
   logic        stallreq;

   int checks = 0;
   int errors = 0;

   sram_port_arbiter_if bus ();

   sram_port_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .inst_done  (inst_done),
      .data_req   (data_req),
      .data_wen   (data_wen),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_rdata (data_rdata),
      .data_done  (data_done),
      .stallreq   (stallreq),
      .mem        (bus.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      inst_req     = 1'b0;
      inst_addr    = 32'h0;
      data_req     = 1'b0;
      data_wen     = 4'h0;
      data_addr    = 32'h0;
      data_wdata   = 32'h0;
      bus.addr_ok  = 1'b0;
      bus.data_ok  = 1'b0;
      bus.rdata    = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
      settle();
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", bus.req); end
      checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", bus.addr); end
      checks++; if (bus.wen !== 4'h0) begin errors++; $display("FAIL reset_mem_wen: got %h expected 0", bus.wen); end
      checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", bus.wdata); end
      checks++; if (inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", inst_rdata, data_rdata); end
      checks++; if (inst_done !== 1'b0 || data_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b/%b expected 0/0", inst_done, data_done); end
      checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b expected 0", stallreq); end
   endtask

   task automatic test_single_load();
      // cycle 0: IDLE, request appears
      tick();
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h1000;
      settle();
      checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL load_c0_stallreq: got %b expected 1", stallreq); end
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL load_c0_mem_req: got %b expected 0", bus.req); end
      // cycle 1: ADDR
      tick();
      bus.addr_ok = 1'b1;
      settle();
      checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL load_c1_mem_req: got %b expected 1", bus.req); end
      checks++; if (bus.addr !== 32'h1000) begin errors++; $display("FAIL load_c1_mem_addr: got %h expected 00001000", bus.addr); end
      checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL load_c1_stallreq: got %b expected 1", stallreq); end
      // cycle 2: DATA
      tick();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hDEADBEEF;
      settle();
      checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL load_c2_mem_req: got %b expected 0", bus.req); end
      checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL load_c2_stallreq: got %b expected 1", stallreq); end
      // cycle 3: RESP
      tick();
      bus.data_ok = 1'b0; bus.rdata = 32'h0; data_req = 1'b0;
      settle();
      checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL load_c3_data_done: got %b expected 1", data_done); end
      checks++; if (data_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_c3_data_rdata: got %h expected deadbeef", data_rdata); end
      checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL load_c3_stallreq: got %b expected 0", stallreq); end
      checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL load_c3_inst_done: got %b expected 0", inst_done); end
      // cycle 4: IDLE again
      tick();
      checks++; if (data_done !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL load_c4_idle: got done=%b stall=%b expected 0/0", data_done, stallreq); end
   endtask

   task automatic test_simultaneous();
      tick();
      inst_req = 1'b1; inst_addr = 32'hBFC00000;
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80;
      settle();
      checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL simul_c0_stallreq: got %b expected 1", stallreq); end
      tick();
      bus.addr_ok = 1'b1;
      settle();
      checks++; if (bus.addr !== 32'h80) begin errors++; $display("FAIL simul_c1_mem_addr: got %h expected 00000080", bus.addr); end
      tick();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h11111111;
      tick();
      bus.data_ok = 1'b0; data_req = 1'b0;
      settle();
      checks++; if (data_done !== 1'b1 || inst_done !== 1'b0) begin errors++; $display("FAIL simul_c3_done: got data=%b inst=%b expected 1/0", data_done, inst_done); end
      // cycle 4: IDLE, fetch still requesting -> granted now, not in RESP
      tick();
      checks++; if (bus.req !== 1'b0 || stallreq !== 1'b1) begin errors++; $display("FAIL simul_c4_idle: got req=%b stall=%b expected 0/1", bus.req, stallreq); end
      tick();
      bus.addr_ok = 1'b1;
      settle();
      checks++; if (bus.req !== 1'b1 || bus.addr !== 32'hBFC00000) begin errors++; $display("FAIL simul_c5_fetch_addr: got req=%b addr=%h expected 1/bfc00000", bus.req, bus.addr); end
      checks++; if (bus.wen !== 4'h0 || bus.wdata !== 32'h0) begin errors++; $display("FAIL simul_c5_fetch_payload: got wen=%h wdata=%h expected 0/0", bus.wen, bus.wdata); end
      tick();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h22222222;
      tick();
      bus.data_ok = 1'b0; inst_req = 1'b0;
      settle();
      checks++; if (inst_done !== 1'b1 || data_done !== 1'b0) begin errors++; $display("FAIL simul_c7_done: got inst=%b data=%b expected 1/0", inst_done, data_done); end
      checks++; if (inst_rdata !== 32'h22222222) begin errors++; $display("FAIL simul_c7_inst_rdata: got %h expected 22222222", inst_rdata); end
      checks++; if (data_rdata !== 32'h11111111) begin errors++; $display("FAIL simul_c7_data_rdata: got %h expected 11111111", data_rdata); end
      tick();
   endtask

   task automatic test_backpressure();
      tick();
      inst_req = 1'b1; inst_addr = 32'h400;
      // cycles 1..3: address withheld
      for (int c = 1; c <= 3; c++) begin
         tick();
         checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h400) begin errors++; $display("FAIL bp_wait_c%0d: got req=%b addr=%h expected 1/00000400", c, bus.req, bus.addr); end
      end
      tick();
      bus.addr_ok = 1'b1;
      settle();
      checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL bp_c4_mem_req: got %b expected 1", bus.req); end
      tick();
      bus.addr_ok = 1'b0;
      settle();
      checks++; if (bus.req !== 1'b0 || stallreq !== 1'b1 || inst_done !== 1'b0) begin errors++; $display("FAIL bp_c5_data_wait: got req=%b stall=%b done=%b expected 0/1/0", bus.req, stallreq, inst_done); end
      tick();
      bus.data_ok = 1'b1; bus.rdata = 32'h33333333;
      settle();
      checks++; if (inst_done !== 1'b0) begin errors++; $display("FAIL bp_c6_early_done: got %b expected 0", inst_done); end
      tick();
      bus.data_ok = 1'b0; inst_req = 1'b0;
      settle();
      checks++; if (inst_done !== 1'b1 || inst_rdata !== 32'h33333333) begin errors++; $display("FAIL bp_c7_done: got done=%b rdata=%h expected 1/33333333", inst_done, inst_rdata); end
      tick();
   endtask

   task automatic test_store();
      tick();
      data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h2000; data_wdata = 32'h12345678;
      tick();
      bus.addr_ok = 1'b1;
      settle();
      checks++; if (bus.wen !== 4'b0011) begin errors++; $display("FAIL store_mem_wen: got %h expected 3", bus.wen); end
      checks++; if (bus.wdata !== 32'h12345678 || bus.addr !== 32'h2000) begin errors++; $display("FAIL store_mem_payload: got wdata=%h addr=%h expected 12345678/00002000", bus.wdata, bus.addr); end
      tick();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hBADBAD00;
      tick();
      bus.data_ok = 1'b0; data_req = 1'b0;
      settle();
      checks++; if (data_done !== 1'b1) begin errors++; $display("FAIL store_done: got %b expected 1", data_done); end
      checks++; if (data_rdata !== 32'h11111111) begin errors++; $display("FAIL store_rdata_kept: got %h expected 11111111", data_rdata); end
      tick();
   endtask

   task automatic test_reset_mid();
      tick();
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h3000;
      tick();
      bus.addr_ok = 1'b1;
      tick();
      // DATA with no data_ok yet: reset here
      bus.addr_ok = 1'b0; rst = 1'b1; data_req = 1'b0;
      tick();
      rst = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hCAFECAFE;
      settle();
      checks++; if (bus.req !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got req=%b stall=%b expected 0/0", bus.req, stallreq); end
      checks++; if (data_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %b expected 0", data_done); end
      checks++; if (data_rdata !== 32'h0 || bus.addr !== 32'h0) begin errors++; $display("FAIL rstmid_values: got rdata=%h addr=%h expected 0/0", data_rdata, bus.addr); end
      tick();
      bus.data_ok = 1'b0;
      settle();
      checks++; if (data_rdata !== 32'h0 || data_done !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL rstmid_late_data_ok: got rdata=%h done=%b stall=%b expected 0/0/0", data_rdata, data_done, stallreq); end
   endtask

   task automatic test_stray();
      tick();
      bus.data_ok = 1'b1; bus.rdata = 32'h55555555;
      tick();
      bus.data_ok = 1'b0;
      data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h44;
      settle();
      checks++; if (data_rdata !== 32'h0 || data_done !== 1'b0) begin errors++; $display("FAIL stray_idle_data_ok: got rdata=%h done=%b expected 0/0", data_rdata, data_done); end
      tick();
      bus.addr_ok = 1'b1; bus.data_ok = 1'b1; bus.rdata = 32'h66666666;
      tick();
      bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
      settle();
      checks++; if (bus.req !== 1'b0 || data_done !== 1'b0 || stallreq !== 1'b1) begin errors++; $display("FAIL stray_data_wait1: got req=%b done=%b stall=%b expected 0/0/1", bus.req, data_done, stallreq); end
      tick();
      bus.data_ok = 1'b1; bus.rdata = 32'h77777777;
      settle();
      checks++; if (data_rdata !== 32'h0 || data_done !== 1'b0) begin errors++; $display("FAIL stray_data_wait2: got rdata=%h done=%b expected 0/0", data_rdata, data_done); end
      tick();
      bus.data_ok = 1'b0; data_req = 1'b0;
      settle();
      checks++; if (data_done !== 1'b1 || data_rdata !== 32'h77777777) begin errors++; $display("FAIL stray_done: got done=%b rdata=%h expected 1/77777777", data_done, data_rdata); end
      tick();
      checks++; if (data_done !== 1'b0 || stallreq !== 1'b0 || bus.addr !== 32'h44) begin errors++; $display("FAIL stray_after: got done=%b stall=%b addr=%h expected 0/0/00000044", data_done, stallreq, bus.addr); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_load();
      test_simultaneous();
      test_backpressure();
      test_store();
      test_reset_mid();
      test_stray();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares the single data-SRAM bus port between the instruction-fetch requester and the MEM-stage data requester. Runs one transaction at a time through a req/addr_ok/data_ok handshake, gives data accesses fixed priority, and raises a stall request so the pipeline stall logic freezes the stages while an access is outstanding. It sits between the IF/MEM stages and the external SRAM-like bus.

## Interface
- No parameters; all widths are fixed at 32-bit address/data and 4-bit byte write-enable.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  fetch request; held with inst_addr stable until inst_done
- inst_addr  in  32  fetch address
- inst_rdata  out  32  fetched word; valid on inst_done and held until the next inst_done
- inst_done  out  1  one-cycle completion pulse for fetch
- data_req  in  1  data request; held with payload stable until data_done
- data_wen  in  4  byte write-enable; 0 = read
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_rdata  out  32  load word; valid on data_done and held until the next read's data_done
- data_done  out  1  one-cycle completion pulse for data
- stallreq  out  1  pipeline stall request
- mem_req  out  1  bus request
- mem_wen  out  4  bus write-enable
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_addr_ok  in  1  bus accepted the address/request this cycle
- mem_data_ok  in  1  bus returns read data or write completion this cycle
- mem_rdata  in  32  bus read data

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - ADDR: mem_req=1, waiting for mem_addr_ok.
  - DATA: waiting for mem_data_ok.
  - RESP: done pulse cycle.
- IDLE, any request present: grant data if data_req=1, else inst. Latch owner, wen, addr and wdata into registers, then go to ADDR.
  - A fetch grant latches wen=0 and wdata=0.
- IDLE, no request: stay in IDLE.
- ADDR: mem_req=1 and the mem_* outputs drive the latched payload. On mem_addr_ok go to DATA; otherwise hold every output unchanged.
- DATA: mem_req=0. On mem_data_ok, capture mem_rdata and go to RESP.
  - The capture updates inst_rdata or data_rdata according to owner.
  - A write (latched wen≠0) does not update data_rdata.
- RESP: the owner's done=1 for exactly this cycle. No new grant is made in RESP, so a still-asserted req is not re-granted. Next state is IDLE.
- Ignored handshake inputs:
  - mem_data_ok outside DATA.
  - mem_addr_ok outside ADDR.
  - mem_data_ok asserted in the same cycle as mem_addr_ok in ADDR (it is not counted).
- Fixed priority: if both requests are present in IDLE, data wins. Fetch is served on the next IDLE if inst_req is still high.
- stallreq is combinational: 1 when state∈{ADDR, DATA}, or when state=IDLE and (inst_req | data_req). 0 in RESP, and 0 in IDLE with no request.
- mem_addr, mem_wen and mem_wdata are registered and change only on a grant.
- Reset values: state=IDLE, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0, inst_rdata=0, data_rdata=0, inst_done=0, data_done=0, owner=inst.

## Timing
- Minimum latency: request first seen in IDLE at cycle 0.
  - Cycle 1: ADDR, mem_req=1; mem_addr_ok arrives the same cycle.
  - Cycle 2: DATA; mem_data_ok arrives the same cycle.
  - Cycle 3: RESP, done=1.
  - Cycle 4: IDLE, next grant possible.
- Each cycle mem_addr_ok or mem_data_ok is late adds exactly one cycle in ADDR or DATA respectively.
- Back-to-back requests: throughput is at most one transaction per 4 cycles.
- Requesters must drop or change req in the cycle after done. If req is still high in the following IDLE, it is treated as a new request.
- rst mid-transaction: the next cycle is IDLE with all reset values applied.
  - mem_req drops immediately.
  - No done pulse is issued for the aborted access.
  - A late mem_data_ok after reset is ignored.

## Test plan
- Single load: data_req=1, wen=0, addr=0x1000; addr_ok in cycle 1, data_ok with rdata=0xDEADBEEF in cycle 2 -> data_done=1 in cycle 3, data_rdata=0xDEADBEEF; stallreq=1 in cycles 0-2, 0 in cycle 3.
- Simultaneous requests: inst_req (0xBFC00000) and data_req (0x80) both raised in cycle 0 -> mem_addr=0x80 first; data_done in cycle 3; mem_addr=0xBFC00000 in cycle 5 (ADDR); inst_done in cycle 7.
- Bus backpressure: addr_ok withheld for 3 cycles, then data_ok 2 cycles after acceptance -> mem_req and mem_addr stay stable through the wait; done appears 7 cycles after the request.
- Store: wen=4'b0011, wdata=0x12345678 -> mem_wen/mem_wdata match the request; data_done pulses; data_rdata keeps its previous value.
- Reset mid-access: rst asserted in DATA -> next cycle IDLE, mem_req=0, no done pulse; a data_ok injected afterwards causes no output change.
- Stray handshakes: data_ok in IDLE, and data_ok together with addr_ok in ADDR -> ignored; the transaction completes only on a later data_ok received in DATA.
